cp0_timer_intc: RTL and testbench

Parametrised CP0 timer and interrupt-pending unit for the MIPS core: it replaces the single Count/Compare pair and the Cause.IP logic inside the CP0 register file with a configurable block. The block provides a prescaled Count, `NUM_CMP` Compare channels with one-shot or periodic mode, sticky timer flags, and the masked 8-bit interrupt-pending vector consumed by the exception logic. It is addressed through the WB-stage CP0 access port using the same `{rd, sel}` 8-bit encoding as the rest of CP0.

---
 rtl/cp0_timer_intc_if.sv | 12 +
 rtl/cp0_timer_intc.sv | 151 +++++++++++++++
 tb/tb_cp0_timer_intc.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_timer_intc_if.sv
// CP0 register access port between the WB stage and the timer/interrupt block.
// Latency: write lands on the next clk edge; read data is combinational.
// Backpressure: none; every access completes in the cycle it is presented.
interface cp0_timer_intc_if;
  logic        reg_we;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;

  modport master (output reg_we, output reg_addr, output reg_wdata, input reg_rdata);
  modport slave  (input reg_we, input reg_addr, input reg_wdata, output reg_rdata);
endinterface

// File: rtl/cp0_timer_intc.sv
// CP0 prescaled Count, NUM_CMP Compare channels (one-shot/periodic), sticky flags, Cause.IP.
// Latency: match at t -> timer_flag at t+1 -> cause_ip[7]/int_pending[7] at t+2.
// Backpressure: none; register accesses always accepted, outputs valid every cycle.
module cp0_timer_intc #(
  parameter int CNT_W    = 32,
  parameter int NUM_CMP  = 2,
  parameter int TICK_DIV = 2
) (
  input  logic               clk,
  input  logic               reset,
  cp0_timer_intc_if.slave    bus,
  input  logic [5:0]         ext_int_in,
  input  logic               status_ie,
  input  logic               status_exl,
  input  logic [7:0]         status_im,
  output logic [7:0]         cause_ip,
  output logic [NUM_CMP-1:0] timer_flag,
  output logic [7:0]         int_pending,
  output logic               int_req
);

  localparam logic [7:0] ADDR_COUNT = 8'h48;
  localparam logic [7:0] ADDR_CMP   = 8'h58;
  localparam logic [7:0] ADDR_PER   = 8'h5C;
  localparam logic [7:0] ADDR_CAUSE = 8'h68;
  localparam logic [7:0] ADDR_TCTL  = 8'hB0;

  logic [3:0]       presc;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] compare [NUM_CMP];
  logic [CNT_W-1:0] period  [NUM_CMP];
  logic [NUM_CMP-1:0] per_mode;
  logic [NUM_CMP-1:0] ch_en;
  logic             frz;

  logic               tick;
  logic               timer_any;
  logic               wr_count;
  logic               wr_cause;
  logic               wr_tctl;
  logic [NUM_CMP-1:0] wr_cmp;
  logic [NUM_CMP-1:0] wr_per;
  logic [NUM_CMP-1:0] match;

  // Frozen count also freezes the prescaler, so no tick can fire while FRZ is set.
  assign tick      = !frz && (presc == 4'(TICK_DIV - 1));
  assign timer_any = |timer_flag;
  assign wr_count  = bus.reg_we && (bus.reg_addr == ADDR_COUNT);
  assign wr_cause  = bus.reg_we && (bus.reg_addr == ADDR_CAUSE);
  assign wr_tctl   = bus.reg_we && (bus.reg_addr == ADDR_TCTL);

  // Per-channel write decode and compare match on registered state.
  always_comb begin
    wr_cmp = '0;
    wr_per = '0;
    match  = '0;
    for (int i = 0; i < NUM_CMP; i++) begin
      wr_cmp[i] = bus.reg_we && (bus.reg_addr == ADDR_CMP + 8'(i));
      wr_per[i] = bus.reg_we && (bus.reg_addr == ADDR_PER + 8'(i));
      match[i]  = ch_en[i] && (count == compare[i]);
    end
  end

  // Prescaler and Count; a COUNT write restarts the prescale period and beats the tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      count <= '0;
    end else if (wr_count) begin
      presc <= '0;
      count <= bus.reg_wdata[CNT_W-1:0];
    end else if (!frz) begin
      if (tick) begin
        presc <= '0;
        count <= count + CNT_W'(1);
      end else begin
        presc <= presc + 4'd1;
      end
    end
  end

  // Compare/period registers and sticky flags; a COMPARE write beats both match and reload.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_flag <= '0;
      for (int i = 0; i < NUM_CMP; i++) begin
        compare[i] <= '1;
        period[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CMP; i++) begin
        if (wr_per[i]) period[i] <= bus.reg_wdata[CNT_W-1:0];
        if (wr_cmp[i]) begin
          compare[i]    <= bus.reg_wdata[CNT_W-1:0];
          timer_flag[i] <= 1'b0;
        end else if (match[i]) begin
          timer_flag[i] <= 1'b1;
          if (per_mode[i]) compare[i] <= compare[i] + period[i];
        end
      end
    end
  end

  // TCTL: mode, enable and freeze bits; never touches flags or compares.
  always_ff @(posedge clk) begin
    if (reset) begin
      per_mode <= '0;
      ch_en    <= NUM_CMP'(1);
      frz      <= 1'b0;
    end else if (wr_tctl) begin
      per_mode <= bus.reg_wdata[NUM_CMP-1:0];
      ch_en    <= bus.reg_wdata[8 +: NUM_CMP];
      frz      <= bus.reg_wdata[16];
    end
  end

  // Cause.IP: hardware lines sampled every cycle, software bits only on a CAUSE write.
  always_ff @(posedge clk) begin
    if (reset) begin
      cause_ip <= '0;
    end else begin
      cause_ip[7]   <= ext_int_in[5] | timer_any;
      cause_ip[6:2] <= ext_int_in[4:0];
      if (wr_cause) cause_ip[1:0] <= bus.reg_wdata[9:8];
    end
  end

  assign int_pending = cause_ip & status_im & {8{status_ie & ~status_exl}};
  assign int_req     = |int_pending;

  // Read mux; unmapped addresses and channels beyond NUM_CMP return zero.
  always_comb begin
    bus.reg_rdata = '0;
    case (bus.reg_addr)
      ADDR_COUNT: bus.reg_rdata = 32'(count);
      ADDR_CAUSE: bus.reg_rdata = {1'b0, timer_any, 14'b0, cause_ip, 8'b0};
      ADDR_TCTL: begin
        bus.reg_rdata[NUM_CMP-1:0]  = per_mode;
        bus.reg_rdata[8 +: NUM_CMP] = ch_en;
        bus.reg_rdata[16]           = frz;
      end
      default: begin
        for (int i = 0; i < NUM_CMP; i++) begin
          if (bus.reg_addr == ADDR_CMP + 8'(i)) bus.reg_rdata = 32'(compare[i]);
          if (bus.reg_addr == ADDR_PER + 8'(i)) bus.reg_rdata = 32'(period[i]);
        end
      end
    endcase
  end

endmodule

// File: tb/tb_cp0_timer_intc.sv
// Directed bench for cp0_timer_intc with CNT_W=16, NUM_CMP=2, TICK_DIV=2.
// Inputs change on the falling edge; outputs are checked shortly after it.
// Expected values are hand-computed cycle by cycle from the write edges.
module tb_cp0_timer_intc;
  localparam logic [7:0] A_COUNT = 8'h48;
  localparam logic [7:0] A_CMP0  = 8'h58;
  localparam logic [7:0] A_CMP1  = 8'h59;
  localparam logic [7:0] A_PER0  = 8'h5C;
  localparam logic [7:0] A_PER1  = 8'h5D;
  localparam logic [7:0] A_CAUSE = 8'h68;
  localparam logic [7:0] A_TCTL  = 8'hB0;

  logic       clk;
  logic       reset;
  logic [5:0] ext_int_in;
  logic       status_ie;
  logic       status_exl;
  logic [7:0] status_im;
  logic [7:0] cause_ip;
  logic [1:0] timer_flag;
  logic [7:0] int_pending;
  logic       int_req;

  int n_chk  = 0;
  int n_fail = 0;

  cp0_timer_intc_if bus ();

  cp0_timer_intc #(.CNT_W(16), .NUM_CMP(2), .TICK_DIV(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .ext_int_in  (ext_int_in),
    .status_ie   (status_ie),
    .status_exl  (status_exl),
    .status_im   (status_im),
    .cause_ip    (cause_ip),
    .timer_flag  (timer_flag),
    .int_pending (int_pending),
    .int_req     (int_req)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    bus.reg_addr = a;
    #1;
    chk(tag, bus.reg_rdata, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.reg_we    = 1'b1;
    bus.reg_addr  = a;
    bus.reg_wdata = d;
    @(negedge clk);
    bus.reg_we    = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    bus.reg_we = 1'b0;
    bus.reg_addr = 8'h00;
    bus.reg_wdata = 32'h0;
    ext_int_in = 6'h00;
    status_ie = 1'b1;
    status_exl = 1'b0;
    status_im = 8'hFF;
    step(2);

    // Reset state
    rd_chk("rst_count", A_COUNT, 32'h0000);
    rd_chk("rst_cmp0", A_CMP0, 32'hFFFF);
    rd_chk("rst_cmp1", A_CMP1, 32'hFFFF);
    rd_chk("rst_per0", A_PER0, 32'h0);
    rd_chk("rst_tctl", A_TCTL, 32'h100);
    chk("rst_cause_ip", 32'(cause_ip), 32'h0);
    chk("rst_flag", 32'(timer_flag), 32'h0);
    chk("rst_int_pending", 32'(int_pending), 32'h0);
    chk("rst_int_req", 32'(int_req), 32'h0);
    reset = 1'b0;

    rd_chk("unmapped_cmp2", 8'h5A, 32'h0);
    rd_chk("unmapped_0", 8'h00, 32'h0);
    wr(A_COUNT, 32'h0001_2345);
    rd_chk("count_trunc", A_COUNT, 32'h2345);

    // Basic match: 4 increments at 2 cycles each
    status_im = 8'h80;
    wr(A_CMP0, 32'h14);
    wr(A_COUNT, 32'h10);
    rd_chk("bm_count_load", A_COUNT, 32'h10);
    step(7);
    rd_chk("bm_count_7", A_COUNT, 32'h13);
    step(1);
    rd_chk("bm_count_8", A_COUNT, 32'h14);
    chk("bm_flag_at_match", 32'(timer_flag), 32'h0);
    step(1);
    chk("bm_flag_t1", 32'(timer_flag), 32'h1);
    chk("bm_int_req_t1", 32'(int_req), 32'h0);
    step(1);
    chk("bm_cause_ip_t2", 32'(cause_ip), 32'h80);
    chk("bm_int_pending_t2", 32'(int_pending), 32'h80);
    chk("bm_int_req_t2", 32'(int_req), 32'h1);
    rd_chk("bm_cause_read", A_CAUSE, 32'h4000_8000);
    wr(A_CMP0, 32'h100);
    chk("bm_flag_cleared", 32'(timer_flag), 32'h0);
    rd_chk("bm_cmp0_read", A_CMP0, 32'h100);

    // Freeze, and compare write racing a match
    wr(A_TCTL, 32'h1_0100);
    rd_chk("frz_tctl", A_TCTL, 32'h1_0100);
    wr(A_COUNT, 32'h40);
    rd_chk("frz_count_load", A_COUNT, 32'h40);
    wr(A_CMP0, 32'h40);
    wr(A_CMP0, 32'h40);
    chk("cmp_write_beats_match", 32'(timer_flag), 32'h0);
    step(1);
    chk("frozen_match_sets", 32'(timer_flag), 32'h1);
    step(50);
    rd_chk("frz_count_held", A_COUNT, 32'h40);

    // COUNT write in a tick cycle
    wr(A_TCTL, 32'h100);
    wr(A_COUNT, 32'h200);
    step(1);
    rd_chk("tick_pre", A_COUNT, 32'h200);
    wr(A_COUNT, 32'h300);
    rd_chk("tick_write_wins", A_COUNT, 32'h300);
    step(1);
    rd_chk("tick_first_hold", A_COUNT, 32'h300);
    step(1);
    rd_chk("tick_first_inc", A_COUNT, 32'h301);

    // Periodic mode on channel 1
    wr(A_CMP0, 32'h1000);
    wr(A_PER1, 32'h20);
    rd_chk("per1_read", A_PER1, 32'h20);
    wr(A_CMP1, 32'h30);
    wr(A_TCTL, 32'h302);
    rd_chk("per_tctl", A_TCTL, 32'h302);
    wr(A_COUNT, 32'h2E);
    step(4);
    rd_chk("per_count_30", A_COUNT, 32'h30);
    chk("per_flag_pre", 32'(timer_flag), 32'h0);
    rd_chk("per_cmp1_pre", A_CMP1, 32'h30);
    step(1);
    chk("per_flag_set", 32'(timer_flag), 32'h2);
    rd_chk("per_cmp1_reload1", A_CMP1, 32'h50);
    step(63);
    rd_chk("per_count_50", A_COUNT, 32'h50);
    rd_chk("per_cmp1_hold", A_CMP1, 32'h50);
    step(1);
    rd_chk("per_cmp1_reload2", A_CMP1, 32'h70);
    chk("per_flag_sticky", 32'(timer_flag), 32'h2);
    wr(A_CMP1, 32'h1000);
    chk("per_flag_cleared", 32'(timer_flag), 32'h0);

    // Wrap-around through 0xFFFF
    wr(A_TCTL, 32'h100);
    wr(A_CMP0, 32'h1);
    wr(A_COUNT, 32'hFFFE);
    step(2);
    rd_chk("wrap_ffff", A_COUNT, 32'hFFFF);
    step(2);
    rd_chk("wrap_0000", A_COUNT, 32'h0000);
    chk("wrap_flag_0", 32'(timer_flag), 32'h0);
    step(2);
    rd_chk("wrap_0001", A_COUNT, 32'h0001);
    chk("wrap_flag_pre", 32'(timer_flag), 32'h0);
    step(1);
    chk("wrap_flag_set", 32'(timer_flag), 32'h1);
    rd_chk("wrap_cmp0_unchanged", A_CMP0, 32'h1);
    step(1);

    // Masking and CAUSE software bits
    status_im = 8'h04;
    ext_int_in = 6'b000001;
    #1;
    chk("mask_ext_latency", 32'(cause_ip), 32'h80);
    chk("mask_pending_pre", 32'(int_pending), 32'h0);
    step(1);
    chk("mask_cause_ip", 32'(cause_ip), 32'h84);
    chk("mask_pending", 32'(int_pending), 32'h04);
    chk("mask_int_req", 32'(int_req), 32'h1);
    status_exl = 1'b1;
    #1;
    chk("mask_exl_pending", 32'(int_pending), 32'h0);
    chk("mask_exl_req", 32'(int_req), 32'h0);
    status_exl = 1'b0;
    wr(A_CAUSE, 32'h300);
    chk("cause_sw_bits", 32'(cause_ip), 32'h87);
    rd_chk("cause_read_sw", A_CAUSE, 32'h4000_8700);

    // Reset mid-run overrides a same-cycle write
    wr(A_COUNT, 32'h1234);
    rd_chk("mr_count_pre", A_COUNT, 32'h1234);
    chk("mr_flag_pre", 32'(timer_flag), 32'h1);
    reset = 1'b1;
    bus.reg_we = 1'b1;
    bus.reg_addr = A_TCTL;
    bus.reg_wdata = 32'h1_0303;
    step(1);
    bus.reg_we = 1'b0;
    rd_chk("mr_tctl", A_TCTL, 32'h100);
    rd_chk("mr_count", A_COUNT, 32'h0);
    rd_chk("mr_cmp0", A_CMP0, 32'hFFFF);
    rd_chk("mr_per1", A_PER1, 32'h0);
    chk("mr_flag", 32'(timer_flag), 32'h0);
    chk("mr_cause_ip", 32'(cause_ip), 32'h0);
    chk("mr_int_req", 32'(int_req), 32'h0);
    reset = 1'b0;
    ext_int_in = 6'h00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
